// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter: state and grant encodings,
// default access timeout.
package mem_arb_defs;

  localparam logic [1:0] st_idle  = 2'd0;
  localparam logic [1:0] st_fetch = 2'd1;
  localparam logic [1:0] st_data  = 2'd2;
  localparam logic [1:0] st_derr  = 2'd3;

  localparam logic gnt_fetch = 1'b0;
  localparam logic gnt_data  = 1'b1;

  localparam int unsigned timeout_dflt = 32;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, data and memory handshake signals of the unified-memory arbiter.
// master is the arbiter's view; slave is the requesters/memory view.
interface mem_arbiter_if;

  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_done;
  logic        if_err;
  logic        if_stall;

  logic        d_rd;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_done;
  logic        d_err;
  logic        d_stall;

  logic        mem_req;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  modport master (
    input  if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, mem_ack, mem_rdata,
    output if_rdata, if_done, if_err, if_stall, d_rdata, d_done, d_err, d_stall,
    output mem_req, mem_wr, mem_addr, mem_wdata
  );

  modport slave (
    output if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, mem_ack, mem_rdata,
    input  if_rdata, if_done, if_err, if_stall, d_rdata, d_done, d_err, d_stall,
    input  mem_req, mem_wr, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_timer.sv
// Access timeout counter: 8-bit, cleared/enabled by the arbiter, flags the last
// allowed cycle of an access.
module arb_timer
  import mem_arb_defs::*;
#(
  parameter int unsigned TIMEOUT = timeout_dflt
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] last_cnt = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == last_cnt);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer serialising instruction fetch and load/store accesses onto a
// single variable-latency memory handshake, with illegal-access and timeout errors.
module mem_arbiter
  import mem_arb_defs::*;
#(
  parameter int unsigned TIMEOUT = timeout_dflt
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.master bus
);

  logic [1:0]  state_q, state_d;
  logic        last_q, last_d;
  logic        req_q, req_d;
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;

  logic in_fetch, in_data, in_derr, active;
  logic expired, ack, tmo, finish;
  logic d_req, d_bad;

  assign in_fetch = (state_q == st_fetch);
  assign in_data  = (state_q == st_data);
  assign in_derr  = (state_q == st_derr);
  assign active   = in_fetch | in_data;

  // Ack wins over an expiry in the same cycle.
  assign ack    = active & bus.mem_ack;
  assign tmo    = active & ~bus.mem_ack & expired;
  assign finish = ack | tmo;

  assign d_req = bus.d_rd | bus.d_wr;
  assign d_bad = d_req & ((bus.d_rd & bus.d_wr) | bus.d_addr[0]);

  arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (~active),
    .en      (active & ~bus.mem_ack),
    .expired (expired)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    req_d   = req_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      st_idle: begin
        // Illegal data requests bypass arbitration and never reach memory.
        if (d_bad) begin
          state_d = st_derr;
        end else if (d_req && (!bus.if_req || last_q == gnt_fetch)) begin
          state_d = st_data;
          req_d   = 1'b1;
          wr_d    = bus.d_wr;
          addr_d  = bus.d_addr;
          wdata_d = bus.d_wdata;
        end else if (bus.if_req) begin
          state_d = st_fetch;
          req_d   = 1'b1;
          wr_d    = 1'b0;
          addr_d  = bus.if_addr;
          wdata_d = '0;
        end
      end
      st_fetch, st_data: begin
        if (finish) begin
          state_d = st_idle;
          req_d   = 1'b0;
        end
        if (ack) begin
          last_d = in_data ? gnt_data : gnt_fetch;
        end
      end
      default: begin
        state_d = st_idle;
        last_d  = gnt_data;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= st_idle;
      last_q  <= gnt_fetch;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      req_q   <= req_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.mem_req   = req_q;
  assign bus.mem_wr    = wr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  assign bus.if_done  = in_fetch & finish;
  assign bus.if_err   = in_fetch & tmo;
  assign bus.if_rdata = (in_fetch & ack) ? bus.mem_rdata : '0;

  assign bus.d_done  = (in_data & finish) | in_derr;
  assign bus.d_err   = (in_data & tmo) | in_derr;
  assign bus.d_rdata = (in_data & ack & ~wr_q) ? bus.mem_rdata : '0;

  assign bus.if_stall = bus.if_req & ~bus.if_done;
  assign bus.d_stall  = d_req & ~bus.d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT=4): fetch, contention, store, illegal
// access, timeout with late ack, and reset in the middle of a data access.
module tb_mem_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .TIMEOUT (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic        is_data;
    logic [15:0] rd;

    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.d_rd      = 1'b0;
    bus.d_wr      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;

    // Reset state
    next();
    next();
    rst_n = 1'b1;
    settle();
    chk1 ("rst_mem_req", bus.mem_req, 1'b0);
    chk1 ("rst_mem_wr", bus.mem_wr, 1'b0);
    chk16("rst_mem_addr", bus.mem_addr, 16'h0000);
    chk16("rst_mem_wdata", bus.mem_wdata, 16'h0000);
    chk1 ("rst_if_done", bus.if_done, 1'b0);
    chk1 ("rst_d_done", bus.d_done, 1'b0);
    chk1 ("rst_d_err", bus.d_err, 1'b0);
    chk1 ("rst_if_err", bus.if_err, 1'b0);
    chk16("rst_if_rdata", bus.if_rdata, 16'h0000);
    chk16("rst_d_rdata", bus.d_rdata, 16'h0000);

    // Fetch only, ack on the third mem_req cycle
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0040;
    settle();
    chk1("f_stall_idle", bus.if_stall, 1'b1);
    chk1("f_req_idle", bus.mem_req, 1'b0);
    next();
    settle();
    chk1 ("f_req_c1", bus.mem_req, 1'b1);
    chk16("f_addr_c1", bus.mem_addr, 16'h0040);
    chk1 ("f_wr_c1", bus.mem_wr, 1'b0);
    chk1 ("f_done_c1", bus.if_done, 1'b0);
    chk1 ("f_stall_c1", bus.if_stall, 1'b1);
    next();
    settle();
    chk1("f_done_c2", bus.if_done, 1'b0);
    chk1("f_stall_c2", bus.if_stall, 1'b1);
    next();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'hA5A5;
    settle();
    chk1 ("f_done_c3", bus.if_done, 1'b1);
    chk16("f_rdata_c3", bus.if_rdata, 16'hA5A5);
    chk1 ("f_err_c3", bus.if_err, 1'b0);
    chk1 ("f_stall_c3", bus.if_stall, 1'b0);
    next();
    bus.mem_ack = 1'b0;
    bus.if_req  = 1'b0;
    settle();
    chk1("f_bubble_req", bus.mem_req, 1'b0);
    chk1("f_bubble_done", bus.if_done, 1'b0);

    // Contention from reset: data first, then strict alternation D,F,D,F
    rst_n = 1'b0;
    next();
    rst_n       = 1'b1;
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0200;
    bus.d_rd    = 1'b1;
    bus.d_addr  = 16'h0100;
    settle();
    chk1("c_req_idle", bus.mem_req, 1'b0);
    for (int i = 0; i < 4; i++) begin
      is_data = (i % 2 == 0);
      rd      = is_data ? 16'h1111 : 16'h2222;
      next();
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = rd;
      settle();
      chk1 ("c_req", bus.mem_req, 1'b1);
      chk16("c_addr", bus.mem_addr, is_data ? 16'h0100 : 16'h0200);
      chk1 ("c_d_done", bus.d_done, is_data);
      chk1 ("c_if_done", bus.if_done, ~is_data);
      chk16("c_rdata", is_data ? bus.d_rdata : bus.if_rdata, rd);
      chk1 ("c_other_stall", is_data ? bus.if_stall : bus.d_stall, 1'b1);
      next();
      bus.mem_ack = 1'b0;
      if (i == 3) begin
        bus.if_req = 1'b0;
        bus.d_rd   = 1'b0;
      end
      settle();
      chk1("c_bubble_req", bus.mem_req, 1'b0);
      chk1("c_bubble_ifd", bus.if_done, 1'b0);
      chk1("c_bubble_dd", bus.d_done, 1'b0);
    end

    // Store; request fields change after grant and must not affect the access
    bus.d_wr    = 1'b1;
    bus.d_addr  = 16'h0202;
    bus.d_wdata = 16'h1234;
    settle();
    chk1("s_stall_idle", bus.d_stall, 1'b1);
    next();
    bus.d_addr  = 16'h0666;
    bus.d_wdata = 16'hBEEF;
    settle();
    chk1 ("s_req", bus.mem_req, 1'b1);
    chk1 ("s_wr", bus.mem_wr, 1'b1);
    chk16("s_addr", bus.mem_addr, 16'h0202);
    chk16("s_wdata", bus.mem_wdata, 16'h1234);
    chk1 ("s_done_c1", bus.d_done, 1'b0);
    next();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'hFFFF;
    settle();
    chk1 ("s_done", bus.d_done, 1'b1);
    chk1 ("s_err", bus.d_err, 1'b0);
    chk16("s_rdata", bus.d_rdata, 16'h0000);
    chk16("s_wdata_hold", bus.mem_wdata, 16'h1234);
    next();
    bus.mem_ack = 1'b0;
    bus.d_wr    = 1'b0;
    settle();
    chk1("s_bubble_req", bus.mem_req, 1'b0);

    // Illegal: misaligned read
    bus.d_rd   = 1'b1;
    bus.d_addr = 16'h0003;
    next();
    settle();
    chk1("im_done", bus.d_done, 1'b1);
    chk1("im_err", bus.d_err, 1'b1);
    chk1("im_req", bus.mem_req, 1'b0);
    next();
    bus.d_rd = 1'b0;
    settle();
    chk1("im_done_after", bus.d_done, 1'b0);
    chk1("im_req_after", bus.mem_req, 1'b0);

    // Illegal: read and write together
    bus.d_rd   = 1'b1;
    bus.d_wr   = 1'b1;
    bus.d_addr = 16'h0010;
    next();
    settle();
    chk1("irw_done", bus.d_done, 1'b1);
    chk1("irw_err", bus.d_err, 1'b1);
    chk1("irw_req", bus.mem_req, 1'b0);
    next();
    bus.d_rd = 1'b0;
    bus.d_wr = 1'b0;
    settle();
    chk1("irw_done_after", bus.d_done, 1'b0);
    chk1("irw_req_after", bus.mem_req, 1'b0);

    // Timeout: no ack for 4 cycles, then a late ack is ignored
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0300;
    for (int c = 1; c <= 4; c++) begin
      next();
      settle();
      chk1("t_req", bus.mem_req, 1'b1);
      chk1("t_done", bus.if_done, (c == 4));
      chk1("t_err", bus.if_err, (c == 4));
    end
    chk16("t_rdata", bus.if_rdata, 16'h0000);
    next();
    bus.if_req = 1'b0;
    settle();
    chk1("t_req_drop", bus.mem_req, 1'b0);
    next();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'h5555;
    settle();
    chk1 ("t_late_ifd", bus.if_done, 1'b0);
    chk1 ("t_late_dd", bus.d_done, 1'b0);
    chk16("t_late_rdata", bus.if_rdata, 16'h0000);
    chk1 ("t_late_req", bus.mem_req, 1'b0);
    next();
    bus.mem_ack = 1'b0;
    settle();
    chk1("t_after_req", bus.mem_req, 1'b0);

    // Reset in the middle of a data access
    bus.d_rd   = 1'b1;
    bus.d_addr = 16'h0400;
    next();
    settle();
    chk1 ("r_req_before", bus.mem_req, 1'b1);
    chk16("r_addr_before", bus.mem_addr, 16'h0400);
    rst_n = 1'b0;
    next();
    rst_n    = 1'b1;
    bus.d_rd = 1'b0;
    settle();
    chk1 ("r_req", bus.mem_req, 1'b0);
    chk1 ("r_done", bus.d_done, 1'b0);
    chk1 ("r_err", bus.d_err, 1'b0);
    chk1 ("r_wr", bus.mem_wr, 1'b0);
    chk16("r_addr", bus.mem_addr, 16'h0000);
    chk16("r_wdata", bus.mem_wdata, 16'h0000);
    chk16("r_d_rdata", bus.d_rdata, 16'h0000);

    // After reset the last grant is FETCH again, so data wins contention
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0500;
    bus.d_rd    = 1'b1;
    bus.d_addr  = 16'h0600;
    next();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'h7777;
    settle();
    chk16("r_first_addr", bus.mem_addr, 16'h0600);
    chk1 ("r_first_ddone", bus.d_done, 1'b1);
    chk16("r_first_rdata", bus.d_rdata, 16'h7777);
    next();
    bus.mem_ack = 1'b0;
    bus.if_req  = 1'b0;
    bus.d_rd    = 1'b0;
    settle();
    chk1("r_final_req", bus.mem_req, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
